// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - op encodings presented on muldiv_unit.op
//   - FSM state type
//   - DIV_ITERS: radix-2 divide iterations (equals operand width)
package mdu_pkg;

    localparam int unsigned DIV_ITERS = 32;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } mdu_state_e;

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Unsigned restoring iterative divider, one quotient bit per cycle, MSB first.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               load operands and begin (one-cycle pulse)
//   cancel              abort an operation in flight
//   dividend, divisor   unsigned operands, sampled on start
//   quotient, remainder result, valid while 'valid' is high
//   valid               one-cycle pulse after the last iteration
//   count               iteration counter
module div_core
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cancel,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        valid,
    output logic [5:0]  count
);

    localparam logic [5:0] LastIter = 6'(DIV_ITERS - 1);

    logic        active_q;
    logic        valid_q;
    logic [5:0]  cnt_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dsr_q;

    // Partial remainder shifted left with the next dividend bit; 33 bits because
    // rem < divisor, so the shifted value can exceed 32 bits.
    logic [32:0] rem_shift;
    logic        fits;
    logic [31:0] rem_next;

    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        fits      = (rem_shift >= {1'b0, dsr_q});
        // When fits, the difference is < divisor and therefore fits in 32 bits.
        rem_next  = fits ? (rem_shift[31:0] - dsr_q) : rem_shift[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dsr_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            if (start) begin
                active_q <= 1'b1;
                cnt_q    <= '0;
                quo_q    <= dividend;
                rem_q    <= '0;
                dsr_q    <= divisor;
            end else if (active_q) begin
                if (cancel) begin
                    active_q <= 1'b0;
                end else begin
                    rem_q <= rem_next;
                    quo_q <= {quo_q[30:0], fits};
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == LastIter) begin
                        active_q <= 1'b0;
                        valid_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign valid     = valid_q;
    assign count     = cnt_q;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS multiply/divide unit and HI/LO write port.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, op       operation request (sampled in idle only) and opcode
//   a, b            rs / rt operands, latched at acceptance
//   cancel          flush: aborts MUL/DIV, masks write strobes
//   busy            unit not idle
//   done            one-cycle result pulse
//   hi, lo          HI/LO write data (hold last result)
//   weh, wel        HI/LO write strobes
module muldiv_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        weh,
    output logic        wel
);

    mdu_state_e state_q, state_d;

    logic        accept;
    logic        op_is_div;
    logic        op_sdiv;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        div_valid;
    logic [5:0]  div_count;
    logic [31:0] div_lo;
    logic [31:0] div_hi;

    logic [31:0] a_q, b_q;
    logic        mul_signed_q;
    logic        q_neg_q, r_neg_q;
    logic [31:0] hi_q, lo_q;
    logic        weh_q, wel_q;

    logic signed [63:0] mul_a, mul_b, prod;

    // Iteration count is kept for debug visibility only.
    logic unused_div_count;
    assign unused_div_count = ^div_count;

    assign accept    = (state_q == StIdle) && start && !cancel;
    assign op_is_div = (op == MDU_DIV) || (op == MDU_DIVU);
    assign op_sdiv   = (op == MDU_DIV);

    // Signed divide runs on magnitudes; signs are reapplied after the core.
    assign div_dividend = (op_sdiv && a[31]) ? -a : a;
    assign div_divisor  = (op_sdiv && b[31]) ? -b : b;
    assign div_lo       = q_neg_q ? -div_quo : div_quo;
    assign div_hi       = r_neg_q ? -div_rem : div_rem;

    // 33x33 signed product of sign/zero-extended operands; the low 64 bits of
    // the extended multiply are exact.
    assign mul_a = {{31{mul_signed_q & a_q[31]}}, mul_signed_q & a_q[31], a_q};
    assign mul_b = {{31{mul_signed_q & b_q[31]}}, mul_signed_q & b_q[31], b_q};
    assign prod  = mul_a * mul_b;

    div_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && op_is_div),
        .cancel    (cancel),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .quotient  (div_quo),
        .remainder (div_rem),
        .valid     (div_valid),
        .count     (div_count)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: state_d = StMul;
                        MDU_DIV, MDU_DIVU:   state_d = StDiv;
                        default:             state_d = StDone;
                    endcase
                end
            end
            StMul:  state_d = cancel ? StIdle : StDone;
            StDiv: begin
                if (cancel) begin
                    state_d = StIdle;
                end else if (div_valid) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
        endcase
    end

    // Outputs; the strobe mask is the only combinational input-to-output path.
    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
        weh  = weh_q & ~cancel;
        wel  = wel_q & ~cancel;
    end

    // Operand latches and result registers; results load only on entry to done.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            mul_signed_q <= 1'b0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            weh_q        <= 1'b0;
            wel_q        <= 1'b0;
        end else begin
            weh_q <= 1'b0;
            wel_q <= 1'b0;
            if (accept) begin
                a_q          <= a;
                b_q          <= b;
                mul_signed_q <= (op == MDU_MULT);
                q_neg_q      <= op_sdiv && (a[31] ^ b[31]);
                r_neg_q      <= op_sdiv && a[31];
                if (op == MDU_MTHI) begin
                    hi_q  <= a;
                    weh_q <= 1'b1;
                end
                if (op == MDU_MTLO) begin
                    lo_q  <= a;
                    wel_q <= 1'b1;
                end
            end
            if (state_q == StMul && !cancel) begin
                hi_q  <= prod[63:32];
                lo_q  <= prod[31:0];
                weh_q <= 1'b1;
                wel_q <= 1'b1;
            end
            if (state_q == StDiv && !cancel && div_valid) begin
                hi_q  <= div_hi;
                lo_q  <= div_lo;
                weh_q <= 1'b1;
                wel_q <= 1'b1;
            end
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        weh;
    logic        wel;

    int checks   = 0;
    int failures = 0;

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo),
        .weh    (weh),
        .wel    (wel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation at the current negedge, then watch it to completion.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] aa, input logic [31:0] bb,
                          input int exp_busy, input int exp_weh, input int exp_wel,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit hold_start, input bit cancel_done);
        int n, done_cnt, done_at, weh_cnt, wel_cnt, stray;
        n = 0; done_cnt = 0; done_at = 0; weh_cnt = 0; wel_cnt = 0; stray = 0;
        start = 1'b1; op = o; a = aa; b = bb;
        @(negedge clk);
        start = hold_start;
        a = 32'hDEADBEEF;
        b = 32'hDEADBEEF;
        while (busy && n < 100) begin
            n++;
            if (done) begin
                done_cnt++;
                done_at = n;
                if (weh) weh_cnt++;
                if (wel) wel_cnt++;
            end else if (weh || wel) begin
                stray++;
            end
            if (done && cancel_done) begin
                cancel = 1'b1;
                #1;
                chk({tag, " weh_masked"}, 32'(weh), 32'd0);
                chk({tag, " wel_masked"}, 32'(wel), 32'd0);
                cancel = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, " busy_cycles"}, 32'(n), 32'(exp_busy));
        chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, " done_cycle"}, 32'(done_at), 32'(exp_busy));
        chk({tag, " weh_count"}, 32'(weh_cnt), 32'(exp_weh));
        chk({tag, " wel_count"}, 32'(wel_cnt), 32'(exp_wel));
        chk({tag, " stray_strobe"}, 32'(stray), 32'd0);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        int dcnt;
        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset weh", 32'(weh), 32'd0);
        chk("reset wel", 32'(wel), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mult", MDU_MULT, 32'hFFFFFFFF, 32'd2, 2, 1, 1,
               32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("multu", MDU_MULTU, 32'hFFFFFFFF, 32'd2, 2, 1, 1,
               32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("div_m7_2", MDU_DIV, 32'hFFFFFFF9, 32'd2, 34, 1, 1,
               32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 34, 1, 1,
               32'h00000000, 32'h80000000, 1'b0, 1'b0);
        run_op("divu_by0", MDU_DIVU, 32'd100, 32'd0, 34, 1, 1,
               32'd100, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 34, 1, 1,
               32'd2, 32'd14, 1'b0, 1'b0);
        run_op("div_7_m2", MDU_DIV, 32'd7, 32'hFFFFFFFE, 34, 1, 1,
               32'd1, 32'hFFFFFFFD, 1'b0, 1'b0);
        // -7 / 0: raw q=0xFFFFFFFF negated, raw r=7 negated.
        run_op("div_m7_by0", MDU_DIV, 32'hFFFFFFF9, 32'd0, 34, 1, 1,
               32'hFFFFFFF9, 32'd1, 1'b0, 1'b0);
        run_op("mthi", MDU_MTHI, 32'h1234, 32'd0, 1, 1, 0,
               32'h1234, 32'd1, 1'b0, 1'b0);
        run_op("mtlo", MDU_MTLO, 32'h5678, 32'd0, 1, 0, 1,
               32'h1234, 32'h5678, 1'b0, 1'b0);
        run_op("undef_op", 3'd7, 32'hAAAA, 32'hBBBB, 1, 0, 0,
               32'h1234, 32'h5678, 1'b0, 1'b0);

        // Cancel a divide at E10, then accept a multiply at E11.
        dcnt = 0;
        start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (done || weh || wel) dcnt++;
            @(negedge clk);
        end
        if (done || weh || wel) dcnt++;
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel busy", 32'(busy), 32'd0);
        chk("cancel done", 32'(done), 32'd0);
        chk("cancel strobes", 32'(dcnt), 32'd0);
        chk("cancel hi", hi, 32'h1234);
        chk("cancel lo", lo, 32'h5678);
        run_op("mult_after_cancel", MDU_MULT, 32'hFFFFFFFD, 32'd5, 2, 1, 1,
               32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);

        run_op("start_while_busy", MDU_DIVU, 32'd100, 32'd7, 34, 1, 1,
               32'd2, 32'd14, 1'b1, 1'b0);
        run_op("cancel_in_done", MDU_MULTU, 32'h00010000, 32'h00010000, 2, 1, 1,
               32'd1, 32'd0, 1'b0, 1'b1);

        // Reset in the middle of a divide.
        start = 1'b1; op = MDU_DIV; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst weh", 32'(weh), 32'd0);
        chk("midrst wel", 32'(wel), 32'd0);
        chk("midrst hi", hi, 32'd0);
        chk("midrst lo", lo, 32'd0);
        rst = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("midrst no_activity", 32'(dcnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit for the MIPS execute stage, and the writer side of the HI/LO register. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations through a start/busy handshake. It computes the 64-bit result and presents it as `hi`/`lo` data with one-cycle `weh`/`wel` write strobes. Those strobes feed the HI/LO register, which captures on the following falling edge.

## Interface
- `DIV_ITERS`, 32: radix-2 divide iterations; equals the operand width and is fixed.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: operation request; sampled only in IDLE.
- `op` in 3: operation code; encodings come from the shared package.
- `a` in 32: rs operand (dividend or multiplicand; data source for MTHI/MTLO).
- `b` in 32: rt operand (divisor or multiplier).
- `cancel` in 1: exception/flush; aborts the operation in flight.
- `busy` out 1: state != IDLE; the pipeline stalls on it.
- `done` out 1: one-cycle result-valid pulse.
- `hi` out 32: HI write data; holds the last result.
- `lo` out 32: LO write data; holds the last result.
- `weh` out 1: HI write strobe.
- `wel` out 1: LO write strobe.

## Operation
- States:
  - IDLE: waits for a request.
  - MUL: one cycle.
  - DIV: DIV_ITERS iteration cycles, then one correction cycle.
  - DONE: one cycle, then returns to IDLE.
- `start` accepted only in IDLE with `cancel`=0. A `start` seen in any other state is ignored and not queued.
- Operands are latched into internal registers at acceptance; `a`/`b` may change afterwards.
- Undefined `op` codes: accepted, but go straight to DONE with `done`=1 and `weh`=`wel`=0.
- MULT: signed 32x32 product, 64-bit two's complement; `hi`=[63:32], `lo`=[31:0].
- MULTU: unsigned 32x32 product, 64-bit; same split.
- DIVU: unsigned restoring division, one quotient bit per cycle, MSB first. `lo`=quotient, `hi`=remainder.
- DIV: divides absolute values, then applies sign correction.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero is fully defined:
  - DIVU: `lo`=0xFFFFFFFF, `hi`=dividend.
  - DIV: same, with the sign rules above applied to the raw result.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0, as the natural result of the abs/negate datapath.
- MTHI: `hi`=`a`, `weh`=1, `wel`=0; `lo` keeps its value.
- MTLO: `lo`=`a`, `wel`=1, `weh`=0; `hi` keeps its value.
- Write strobes in DONE:
  - Registered strobes: both 1 for multiply/divide; the selected one only for MTHI/MTLO.
  - Output: `weh`/`wel` = registered strobe AND NOT `cancel`. This is the only combinational input-to-output path.
- `cancel`=1 at an edge in MUL or DIV: next state IDLE; `hi`/`lo` unchanged; no `done`.
- `rst` has priority over everything, including mid-operation. Reset values:
  - state IDLE
  - `busy`=0, `done`=0, `weh`=0, `wel`=0
  - `hi`=0, `lo`=0
  - iteration counter 0

## Timing
- E0 is the rising edge that samples an accepted `start`.
- MULT/MULTU:
  - MUL in the cycle after E0.
  - Product registered at E1; DONE in the cycle after E1.
  - Back to IDLE at E2. `busy` is high for 2 cycles.
- DIV/DIVU:
  - Iterations at E1..E32.
  - Sign correction and output register at E33; DONE in the cycle after E33.
  - IDLE at E34. `busy` is high for 34 cycles.
- MTHI/MTLO: DONE in the cycle after E0; `busy` is high for 1 cycle.
- `done`, `weh`, `wel` are high for exactly one cycle per completed operation.
- Earliest next accept is E2, E34 or E1 respectively; back-to-back operations are never overlapped.
- `hi`/`lo` change only at the edge entering DONE.

## Structure
- Shared package `mdu_pkg` holds:
  - op encodings: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5
  - state enum
  - DIV_ITERS constant
- Sub-module `div_core`:
  - unsigned restoring iterative divider
  - ports: start/cancel in, quotient/remainder/valid out, 6-bit iteration counter
- Top level contains the FSM, abs/negate logic, the 33x33 signed multiplier (operands extended with a sign or zero bit), and the output registers.

## Test plan
- Multiply, `a`=0xFFFFFFFF, `b`=2, checked against the E0/E1/E2 timing above:
  - MULT -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
  - MULTU -> `hi`=0x00000001, `lo`=0xFFFFFFFE.
  - In both cases `done`/`weh`/`wel` are high only in the cycle after E1, and `busy` is high for 2 cycles.
- Signed divide:
  - DIV `a`=0xFFFFFFF9 (-7), `b`=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF, `done` in the cycle after E33, `busy` high for 34 cycles.
  - DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU 100/0 -> `lo`=0xFFFFFFFF, `hi`=100; DIVU 100/7 -> `lo`=14, `hi`=2.
- Abort and reset:
  - `cancel` pulsed at E10 of a DIV -> `busy`=0 after E10, no strobes, `hi`/`lo` unchanged; a new MULT accepted at E11 completes normally.
  - `rst` asserted mid-DIV -> every output takes its reset value after that edge.
- Handshake rules:
  - MTHI `a`=0x1234 -> only `weh` pulses, `hi`=0x1234, `lo` unchanged.
  - `start` asserted while busy -> ignored, no extra `done`.
  - `cancel` during DONE -> `weh`=`wel`=0 that cycle.
